stream_writer: RTL and testbench

Parametrised sequential memory writer. Buffers incoming words in an internal FIFO and writes them to a memory_w-style single-port write interface. Addresses are generated from a programmable base, stride and word count. It replaces the fixed +1, 32-bit, unbuffered write path and sits between a producer (JIT code emitter / stack spill) and the RAM write port.

---
 rtl/stream_writer.sv | 193 +++++++++++++++++++
 tb/tb_stream_writer.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_writer.sv
// stream_writer: buffers producer words in a small FIFO and writes them to a
// single-port memory write interface. Addresses start at a programmable base
// and advance by a programmable stride, for a programmable word count.
//
// Optional feature macro: WRITE_WRAP_EN adds cfg_limit. When the next address
// reaches or passes the limit, it reloads the base, giving a circular buffer.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   cfg_start          job start pulse, only sampled while idle
//   cfg_base/stride    first address and per-word address increment
//   cfg_count          words in the job (0 = empty job)
//   cfg_limit          wrap limit (only with WRITE_WRAP_EN)
//   in_valid/in_data   producer word, accepted when in_ready is high
//   in_ready           FIFO not full (combinational)
//   mem_start          one-cycle write request
//   mem_address        write address
//   mem_data_in        write data
//   mem_ready          memory write complete / idle
//   busy               job in progress
//   done               one-cycle pulse at job end
//   words_written      words completed in the current/last job

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif

module stream_writer #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = `ADDRESS_WIDTH,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned FIFO_AW       = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic [ADDRESS_WIDTH-1:0] cfg_base,
    input  logic [ADDRESS_WIDTH-1:0] cfg_stride,
    input  logic [ADDRESS_WIDTH-1:0] cfg_count,
`ifdef WRITE_WRAP_EN
    input  logic [ADDRESS_WIDTH-1:0] cfg_limit,
`endif
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     mem_start,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic                     mem_ready,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] words_written
);

    localparam int unsigned CNT_W = FIFO_AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    logic [DATA_WIDTH-1:0]    r_fifo [FIFO_DEPTH];
    logic [FIFO_AW-1:0]       r_wr_ptr;
    logic [FIFO_AW-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic [ADDRESS_WIDTH-1:0] r_cur_addr;
    logic [ADDRESS_WIDTH-1:0] r_stride;
    logic [ADDRESS_WIDTH-1:0] r_remaining;
    logic [ADDRESS_WIDTH-1:0] r_words_written;
    logic [ADDRESS_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0]    r_mem_data_in;
    logic                     r_mem_start;
    logic                     r_done;
`ifdef WRITE_WRAP_EN
    logic [ADDRESS_WIDTH-1:0] r_base;
    logic [ADDRESS_WIDTH-1:0] r_limit;
`endif

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic [ADDRESS_WIDTH-1:0] w_next_addr;
    logic [ADDRESS_WIDTH-1:0] w_step_addr;

    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = (r_state == S_FETCH) && !w_empty;
    assign in_ready = !w_full;

    assign w_step_addr = r_cur_addr + r_stride;
`ifdef WRITE_WRAP_EN
    // A limit at or below the base disables wrapping.
    assign w_next_addr = ((r_limit > r_base) && (w_step_addr >= r_limit)) ? r_base : w_step_addr;
`else
    assign w_next_addr = w_step_addr;
`endif

    assign mem_start     = r_mem_start;
    assign mem_address   = r_mem_address;
    assign mem_data_in   = r_mem_data_in;
    assign done          = r_done;
    assign words_written = r_words_written;
    assign busy          = (r_state != S_IDLE);

    // FIFO storage: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Job FSM with registered memory-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_cur_addr      <= '0;
            r_stride        <= '0;
            r_remaining     <= '0;
            r_words_written <= '0;
            r_mem_address   <= '0;
            r_mem_data_in   <= '0;
            r_mem_start     <= 1'b0;
            r_done          <= 1'b0;
`ifdef WRITE_WRAP_EN
            r_base          <= '0;
            r_limit         <= '0;
`endif
        end else begin
            r_mem_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_cur_addr      <= cfg_base;
                        r_stride        <= cfg_stride;
                        r_remaining     <= cfg_count;
                        r_words_written <= '0;
`ifdef WRITE_WRAP_EN
                        r_base          <= cfg_base;
                        r_limit         <= cfg_limit;
`endif
                        r_state         <= (cfg_count == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!w_empty) begin
                        r_mem_data_in <= r_fifo[r_rd_ptr];
                        r_mem_address <= r_cur_addr;
                        r_mem_start   <= 1'b1;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // mem_ready is ignored while the request pulse is still high.
                    if (!r_mem_start && mem_ready) begin
                        r_cur_addr      <= w_next_addr;
                        r_remaining     <= r_remaining - ADDRESS_WIDTH'(1);
                        r_words_written <= r_words_written + ADDRESS_WIDTH'(1);
                        r_state         <= (r_remaining == ADDRESS_WIDTH'(1)) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_writer.sv
// Self-checking bench for stream_writer: randomized jobs checked against a
// queue-based reference of the expected (address, data) write sequence.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif

module tb_stream_writer;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = `ADDRESS_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_stride;
    logic [AW-1:0] cfg_count;
`ifdef WRITE_WRAP_EN
    logic [AW-1:0] cfg_limit;
`endif
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_start;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] words_written;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] model_q[$];

    int resp_delay = 2;
    int pend = 0;
    bit pending = 0;
    bit hold_ready = 0;
    bit start_prev = 0;
    int multi_start = 0;
    int done_cnt = 0;

    stream_writer dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_base      (cfg_base),
        .cfg_stride    (cfg_stride),
        .cfg_count     (cfg_count),
`ifdef WRITE_WRAP_EN
        .cfg_limit     (cfg_limit),
`endif
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_start     (mem_start),
        .mem_address   (mem_address),
        .mem_data_in   (mem_data_in),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    // Memory model on the falling edge: logs writes, answers each request
    // resp_delay cycles later with a one-cycle mem_ready, counts done pulses.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_start) begin
                wa.push_back(mem_address);
                wd.push_back(mem_data_in);
                if (start_prev) multi_start++;
                pending = 1;
                pend = resp_delay;
            end else if (pending && !hold_ready) begin
                if (pend <= 1) begin
                    mem_ready = 1'b1;
                    pending = 0;
                end else begin
                    pend--;
                end
            end
            start_prev = mem_start;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address of the i-th word of a job, straight from the addressing rules.
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] b, input logic [AW-1:0] s,
                                                 input logic [AW-1:0] l, input int i);
        logic [63:0]   t;
        logic [AW-1:0] a;
`ifdef WRITE_WRAP_EN
        if (l > b) begin
            a = b;
            for (int k = 0; k < i; k++) begin
                a = a + s;
                if (a >= l) a = b;
            end
            return a;
        end
`endif
        t = 64'(b) + 64'(i) * 64'(s);
        a = t[AW-1:0];
        if (l == '1) a = a;  // l only matters when wrapping is built in
        return a;
    endfunction

    task automatic model_job(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input logic [AW-1:0] l, input int c);
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < c; i++) begin
            exp_a.push_back(model_addr(b, s, l, i));
            if (model_q.size() > 0) exp_d.push_back(model_q.pop_front());
            else exp_d.push_back('x);
        end
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input logic [AW-1:0] c, input logic [AW-1:0] l);
        cfg_base = b;
        cfg_stride = s;
        cfg_count = c;
`ifdef WRITE_WRAP_EN
        cfg_limit = l;
`else
        if (l != '0) cfg_count = c;
`endif
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        bit ok = 0;
        in_data = d;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (in_ready) ok = 1;
            tick();
        end
        in_valid = 1'b0;
        if (ok) model_q.push_back(d);
        else begin
            checks++; errors++;
            $display("FAIL push_timeout in_ready stayed %0b, required 1", in_ready);
        end
    endtask

    task automatic wait_done(input int d0, input string nm);
        for (int k = 0; k < 2000 && done_cnt == d0; k++) tick();
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout done_cnt=%0d, required >%0d", nm, done_cnt, d0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cfg_start = 0; cfg_base = 0; cfg_stride = 0; cfg_count = 0;
`ifdef WRITE_WRAP_EN
        cfg_limit = 0;
`endif
        in_valid = 0; in_data = 0;
        #2;
        checks++;
        if ({mem_start, mem_address, mem_data_in, done, words_written, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got start=%0b addr=%h data=%h done=%0b ww=%0d busy=%0b, required all 0",
                     mem_start, mem_address, mem_data_in, done, words_written, busy);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        int ms0 = multi_start;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        resp_delay = 2;
        for (int i = 0; i < 4; i++) push_word($urandom);
        start_job(AW'(16'h10), AW'(1), AW'(4), '0);
        model_job(AW'(16'h10), AW'(1), '0, 4);
        wait_done(d0, "basic");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa.size() == 0) begin
                errors++; $display("FAIL basic_write%0d got none, required %h/%h", i, exp_a[i], exp_d[i]);
            end else begin
                ga = wa.pop_front(); gd = wd.pop_front();
                if (ga !== exp_a[i] || gd !== exp_d[i]) begin
                    errors++; $display("FAIL basic_write%0d got %h/%h, required %h/%h", i, ga, gd, exp_a[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (words_written !== AW'(4) || multi_start != ms0 || done_cnt != d0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got ww=%0d long_starts=%0d dones=%0d busy=%0b, required 4 0 1 0",
                     words_written, multi_start - ms0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_stall();
        int d0 = done_cnt;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        resp_delay = 1;
        start_job(AW'(16'h100), AW'(4), AW'(3), '0);
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1 || wa.size() != 0 || words_written !== '0) begin
            errors++;
            $display("FAIL stall_fetch got busy=%0b writes=%0d ww=%0d, required 1 0 0", busy, wa.size(), words_written);
        end
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(2, 5)) tick();
            push_word($urandom);
        end
        model_job(AW'(16'h100), AW'(4), '0, 3);
        wait_done(d0, "stall");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wa.size() == 0) begin
                errors++; $display("FAIL stall_write%0d got none, required %h/%h", i, exp_a[i], exp_d[i]);
            end else begin
                ga = wa.pop_front(); gd = wd.pop_front();
                if (ga !== exp_a[i] || gd !== exp_d[i]) begin
                    errors++; $display("FAIL stall_write%0d got %h/%h, required %h/%h", i, ga, gd, exp_a[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_empty_job();
        int n0 = wa.size();
        int d0 = done_cnt;
        start_job(AW'(16'h55), AW'(1), AW'(0), '0);
        // One edge after cfg_start the job sits in its final state.
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL empty_cycle1 got busy=%0b done=%0b, required 1 0", busy, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL empty_cycle2 got busy=%0b done=%0b, required 0 1", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || wa.size() != n0 || done_cnt != d0 + 1 || words_written !== '0) begin
            errors++;
            $display("FAIL empty_after got done=%0b writes=%0d dones=%0d ww=%0d, required 0 0 1 0",
                     done, wa.size() - n0, done_cnt - d0, words_written);
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt;
        int acc = 0;
        bit ok;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        hold_ready = 1;
        resp_delay = 1;
        start_job(AW'(16'h200), AW'(1), AW'(9), '0);
        for (int i = 0; i < 10; i++) begin
            ok = 0;
            in_data = $urandom;
            in_valid = 1'b1;
            for (int k = 0; k < 3 && !ok; k++) begin
                if (in_ready) begin
                    ok = 1;
                    model_q.push_back(in_data);
                end
                tick();
            end
            in_valid = 1'b0;
            if (ok) acc++;
        end
        checks++;
        if (in_ready !== 1'b0 || acc != 9 || wa.size() != 1) begin
            errors++;
            $display("FAIL bp_full got in_ready=%0b accepted=%0d writes=%0d, required 0 9 1", in_ready, acc, wa.size());
        end
        hold_ready = 0;
        model_job(AW'(16'h200), AW'(1), '0, 9);
        wait_done(d0, "bp");
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (wa.size() == 0) begin
                errors++; $display("FAIL bp_write%0d got none, required %h/%h", i, exp_a[i], exp_d[i]);
            end else begin
                ga = wa.pop_front(); gd = wd.pop_front();
                if (ga !== exp_a[i] || gd !== exp_d[i]) begin
                    errors++; $display("FAIL bp_write%0d got %h/%h, required %h/%h", i, ga, gd, exp_a[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (wa.size() != 0 || words_written !== AW'(9) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_end got extra=%0d ww=%0d in_ready=%0b, required 0 9 1", wa.size(), words_written, in_ready);
        end
    endtask

    task automatic test_midjob_reset();
        int d0;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        hold_ready = 1;
        start_job(AW'(16'h40), AW'(1), AW'(5), '0);
        push_word($urandom);
        push_word($urandom);
        push_word($urandom);
        for (int k = 0; k < 50 && wa.size() == 0; k++) tick();
        d0 = done_cnt;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_start, mem_address, mem_data_in, done, words_written, busy} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs got start=%0b addr=%h data=%h done=%0b ww=%0d busy=%0b rdy=%0b, required 0s and rdy 1",
                     mem_start, mem_address, mem_data_in, done, words_written, busy, in_ready);
        end
        tick();
        reset = 1'b1;
        hold_ready = 0;
        pending = 0;
        model_q.delete();
        wa.delete();
        wd.delete();
        repeat (4) tick();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || wa.size() != 0) begin
            errors++;
            $display("FAIL midreset_abort got dones=%0d busy=%0b writes=%0d, required 0 0 0", done_cnt - d0, busy, wa.size());
        end
        // Buffered words must be gone: the next job writes only the fresh word.
        push_word($urandom);
        start_job(AW'(16'h50), AW'(2), AW'(1), '0);
        model_job(AW'(16'h50), AW'(2), '0, 1);
        wait_done(d0, "midreset");
        checks++;
        if (wa.size() != 1) begin
            errors++; $display("FAIL midreset_next got %0d writes, required 1", wa.size());
        end else begin
            ga = wa.pop_front(); gd = wd.pop_front();
            if (ga !== exp_a[0] || gd !== exp_d[0]) begin
                errors++; $display("FAIL midreset_next got %h/%h, required %h/%h", ga, gd, exp_a[0], exp_d[0]);
            end
        end
        wa.delete(); wd.delete();
    endtask

    task automatic test_random();
        logic [AW-1:0] b, s, ga;
        logic [DW-1:0] gd;
        int c, d0;
        for (int j = 0; j < 8; j++) begin
            d0 = done_cnt;
            b = AW'($urandom);
            s = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 300));
            c = $urandom_range(1, 8);
            resp_delay = $urandom_range(1, 3);
            start_job(b, s, AW'(c), '0);
            for (int i = 0; i < c; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                push_word($urandom);
            end
            model_job(b, s, '0, c);
            wait_done(d0, "rand");
            for (int i = 0; i < c; i++) begin
                checks++;
                if (wa.size() == 0) begin
                    errors++; $display("FAIL rand%0d_write%0d got none, required %h/%h", j, i, exp_a[i], exp_d[i]);
                end else begin
                    ga = wa.pop_front(); gd = wd.pop_front();
                    if (ga !== exp_a[i] || gd !== exp_d[i]) begin
                        errors++; $display("FAIL rand%0d_write%0d got %h/%h, required %h/%h", j, i, ga, gd, exp_a[i], exp_d[i]);
                    end
                end
            end
            checks++;
            if (words_written !== AW'(c) || wa.size() != 0) begin
                errors++; $display("FAIL rand%0d_count got ww=%0d extra=%0d, required %0d 0", j, words_written, wa.size(), c);
            end
        end
    endtask

`ifdef WRITE_WRAP_EN
    task automatic test_wrap();
        int d0 = done_cnt;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        logic [AW-1:0] req [5];
        req = '{AW'(16'h20), AW'(16'h21), AW'(16'h22), AW'(16'h20), AW'(16'h21)};
        resp_delay = 1;
        for (int i = 0; i < 5; i++) push_word($urandom);
        start_job(AW'(16'h20), AW'(1), AW'(5), AW'(16'h23));
        model_job(AW'(16'h20), AW'(1), AW'(16'h23), 5);
        wait_done(d0, "wrap");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wa.size() == 0) begin
                errors++; $display("FAIL wrap_write%0d got none, required %h/%h", i, req[i], exp_d[i]);
            end else begin
                ga = wa.pop_front(); gd = wd.pop_front();
                if (ga !== req[i] || gd !== exp_d[i]) begin
                    errors++; $display("FAIL wrap_write%0d got %h/%h, required %h/%h", i, ga, gd, req[i], exp_d[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_empty_job();
        test_backpressure();
        test_midjob_reset();
        test_random();
`ifdef WRITE_WRAP_EN
        test_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
